// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode constants, target FSM encoding, idle word.
// Common to the SPI master and the SPI target.
package spi_pkg;

  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b1;

  localparam int         DWIDTH_DEF  = 8;
  localparam logic [7:0] TX_IDLE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchroniser for an asynchronous SPI line.
// Gives the synchronised level plus one-cycle rise/fall strobes.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign lvl  = s2_q;
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/spi_slave_target.sv
// SPI target, CPOL=0/CPHA=1, MSB first, oversampled in the clk domain.
// Optional rx_overrun/tx_underrun flags via SPI_SLAVE_OVERRUN_EN.
module spi_slave_target
  import spi_pkg::*;
#(
  parameter int                DWIDTH  = DWIDTH_DEF,
  parameter logic [DWIDTH-1:0] TX_IDLE = DWIDTH'(TX_IDLE_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
`ifdef SPI_SLAVE_OVERRUN_EN
  output logic              rx_overrun,
  output logic              tx_underrun,
`endif
  output logic              active
);

  localparam int            CW   = (DWIDTH > 2) ? $clog2(DWIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWIDTH - 1);

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
    .clk (clk),
    .rst (rst),
    .d   (ss_n),
    .lvl (ss_lvl),
    .rise(ss_rise),
    .fall(ss_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk (clk),
    .rst (rst),
    .d   (sclk),
    .lvl (sclk_lvl),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  spi_state_e        state_q, state_d;
  logic              mosi_s1_q, mosi_s2_q;
  logic              miso_q, miso_d;
  logic              active_q, active_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DWIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DWIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DWIDTH-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DWIDTH-1:0] hold_q, hold_d;
  logic              tx_ready_q, tx_ready_d;
  logic              word_done, load_now;

  always_comb begin
    state_d    = state_q;
    miso_d     = miso_q;
    active_d   = active_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    word_done  = 1'b0;
    load_now   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        active_d  = 1'b0;
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        if (!ss_lvl) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load_now   = 1'b1;
        tx_shift_d = tx_ready_q ? TX_IDLE : hold_q;
        active_d   = 1'b1;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ss_lvl) begin
          state_d   = ST_IDLE;
          active_d  = 1'b0;
          miso_d    = 1'b0;
          bit_cnt_d = '0;
        end else if (sclk_rise) begin
          miso_d     = tx_shift_q[DWIDTH-1];
          tx_shift_d = tx_shift_q << 1;
        end else if (sclk_fall) begin
          rx_shift_d = {rx_shift_q[DWIDTH-2:0], mosi_s2_q};
          if (bit_cnt_q == LAST) begin
            rx_data_d = rx_shift_d;
            word_done = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_LOAD;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A tx_load coinciding with LOAD lands in the holding register after LOAD used the old word.
  always_comb begin
    hold_d     = hold_q;
    tx_ready_d = tx_ready_q;
    if (load_now && !tx_ready_q) tx_ready_d = 1'b1;
    if (tx_load) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end
    rx_valid_d = rx_valid_q;
    if (rx_ack)    rx_valid_d = 1'b0;
    if (word_done) rx_valid_d = 1'b1;
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic ovr_q, ovr_d;
  logic unr_q, unr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (rx_ack) ovr_d = 1'b0;
    if (word_done && rx_valid_q && !rx_ack) ovr_d = 1'b1;
    unr_d = unr_q;
    if (tx_load) unr_d = 1'b0;
    if (load_now && tx_ready_q) unr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
      unr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
      unr_q <= unr_d;
    end
  end

  assign rx_overrun  = ovr_q;
  assign tx_underrun = unr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      miso_q     <= 1'b0;
      active_q   <= 1'b0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      hold_q     <= '0;
      tx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      mosi_s1_q  <= mosi;
      mosi_s2_q  <= mosi_s1_q;
      miso_q     <= miso_d;
      active_q   <= active_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      hold_q     <= hold_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, ss_rise, ss_fall, rx_shift_q[DWIDTH-1]};

  assign miso     = miso_q;
  assign active   = active_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_target.sv
// Self-checking bench for spi_slave_target: vector table, corner
// sequences and random frames against a word-level reference model.
module tb_spi_slave_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss_n = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       active;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       rx_overrun;
  logic       tx_underrun;
`endif

  always #5 clk = ~clk;

  spi_slave_target dut (
    .clk        (clk),
    .rst        (rst),
    .ss_n       (ss_n),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
`ifdef SPI_SLAVE_OVERRUN_EN
    .rx_overrun (rx_overrun),
    .tx_underrun(tx_underrun),
`endif
    .active     (active)
  );

  int n_cmp = 0;
  int n_err = 0;

  // word-level reference model
  logic       exp_ready = 1'b1;
  logic [7:0] exp_hold  = 8'h00;
  logic [7:0] exp_rxd   = 8'h00;
  logic       exp_rxv   = 1'b0;
  logic       exp_ovr   = 1'b0;
  logic       exp_unr   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load   = 1'b0;
    exp_hold  = d;
    exp_ready = 1'b0;
    exp_unr   = 1'b0;
  endtask

  task automatic do_ack;
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack  = 1'b0;
    exp_rxv = 1'b0;
    exp_ovr = 1'b0;
  endtask

  task automatic model_start(output logic [7:0] w);
    if (exp_ready) begin
      w       = 8'hFF;
      exp_unr = 1'b1;
    end else begin
      w         = exp_hold;
      exp_ready = 1'b1;
    end
  endtask

  task automatic model_done(input logic [7:0] w);
    if (exp_rxv) exp_ovr = 1'b1;
    exp_rxv = 1'b1;
    exp_rxd = w;
  endtask

  task automatic check_state;
    chk("rx_data", rx_data, exp_rxd);
    chk("rx_valid", rx_valid, exp_rxv);
    chk("tx_ready", tx_ready, exp_ready);
    chk("active_idle", active, 0);
    chk("miso_idle", miso, 0);
`ifdef SPI_SLAVE_OVERRUN_EN
    chk("rx_overrun", rx_overrun, exp_ovr);
    chk("tx_underrun", tx_underrun, exp_unr);
`endif
  endtask

  // master side: drive mosi on rise, capture miso just before fall
  task automatic xfer(input logic [7:0] w, input int nbits, input bit lat,
                      output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      mosi = w[7-i];
      cyc(4);
      got[7-i] = miso;
      sclk = 1'b0;
      if (lat && i == nbits - 1) begin
        @(posedge clk);
        @(posedge clk);
        #1 chk("rx_valid_lat2", rx_valid, 0);
        @(posedge clk);
        #1 chk("rx_valid_lat3", rx_valid, 1);
        cyc(1);
        cyc(1);
      end else begin
        cyc(4);
      end
    end
  endtask

  task automatic frame(input logic [7:0] w0, input logic [7:0] w1,
                       input int nw, input bit lat,
                       output logic [7:0] got0);
    logic [7:0] e, g, w;
    got0 = 8'h00;
    ss_n = 1'b0;
    cyc(8);
    chk("active_frame", active, 1);
    for (int k = 0; k < nw; k++) begin
      w = (k == 0) ? w0 : w1;
      model_start(e);
      xfer(w, 8, lat && (k == nw - 1), g);
      chk("miso_word", g, e);
      model_done(w);
      if (k == 0) got0 = g;
    end
    cyc(4);
    ss_n = 1'b1;
    cyc(8);
    check_state();
  endtask

  typedef struct {
    logic [7:0] txw;
    bit         load;
    logic [7:0] rxw;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t tbl[3];

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] g, e, w0, w1;
    tbl[0] = '{txw: 8'hA5, load: 1'b1, rxw: 8'h3C,
               exp_miso: 8'hA5, exp_rx: 8'h3C};
    tbl[1] = '{txw: 8'h00, load: 1'b0, rxw: 8'h81,
               exp_miso: 8'hFF, exp_rx: 8'h81};
    tbl[2] = '{txw: 8'h5A, load: 1'b1, rxw: 8'hC3,
               exp_miso: 8'h5A, exp_rx: 8'hC3};

    // reset values
    cyc(3);
    chk("rst_miso", miso, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_active", active, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sclk = ~sclk;
      mosi = ~mosi;
      cyc(4);
    end
    sclk = 1'b0;
    cyc(2);
    check_state();

    // vector table
    for (int i = 0; i < 3; i++) begin
      if (exp_rxv) do_ack();
      if (tbl[i].load) do_load(tbl[i].txw);
      frame(tbl[i].rxw, 8'h00, 1, (i == 0), g);
      chk("tbl_miso", g, tbl[i].exp_miso);
      chk("tbl_rx", rx_data, tbl[i].exp_rx);
      chk("tbl_ready", tx_ready, 1);
    end

    // back-to-back words, no ack
    do_ack();
    frame(8'h12, 8'h34, 2, 1'b0, g);
    chk("b2b_rx", rx_data, 8'h34);
    chk("b2b_valid", rx_valid, 1);
`ifdef SPI_SLAVE_OVERRUN_EN
    chk("b2b_ovr", rx_overrun, 1);
`endif
    do_ack();
    check_state();

    // ss_n raised after 5 bits
    do_load(8'h66);
    ss_n = 1'b0;
    cyc(8);
    model_start(e);
    xfer(8'hF0, 5, 1'b0, g);
    cyc(4);
    ss_n = 1'b1;
    cyc(8);
    check_state();
    chk("abort_valid", rx_valid, 0);
    frame(8'h55, 8'h00, 1, 1'b0, g);
    chk("abort_next_rx", rx_data, 8'h55);

    // rst after bit 3 with ss_n held low
    do_ack();
    do_load(8'h3A);
    ss_n = 1'b0;
    cyc(8);
    model_start(e);
    xfer(8'h99, 3, 1'b0, g);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_miso", miso, 0);
    chk("mrst_tx_ready", tx_ready, 1);
    chk("mrst_rx_data", rx_data, 0);
    chk("mrst_rx_valid", rx_valid, 0);
    chk("mrst_active", active, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_ready = 1'b1;
    exp_rxd   = 8'h00;
    exp_rxv   = 1'b0;
    exp_ovr   = 1'b0;
    exp_unr   = 1'b0;
    frame(8'h99, 8'h00, 1, 1'b0, g);
    chk("mrst_next_rx", rx_data, 8'h99);
    chk("mrst_next_miso", g, 8'hFF);

    // random frames against the model
    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(1, 0) == 1) do_ack();
      if ($urandom_range(1, 0) == 1) do_load(8'($urandom));
      w0 = 8'($urandom);
      w1 = 8'($urandom);
      frame(w0, w1, int'($urandom_range(2, 1)), 1'b0, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_target.md
Name: spi_slave_target

Overview:
- SPI target (slave) endpoint for the far end of the wire driven by our SPI master core; consumes sclk/mosi/ss_n and produces miso.
- Mode fixed at CPOL=0, CPHA=1 to match the master: shift out on the rising (leading) sclk edge, sample on the falling (trailing) edge, MSB first.
- sclk, ss_n and mosi are oversampled in the system clock domain, so sclk must be at most clk/8.
- Parallel side is a small TX holding register and an RX holding register with a valid/ack handshake; used as the bench target and as an on-chip SPI peripheral.

Parameters:
- DWIDTH, 8, frame/word width in bits.
- TX_IDLE, 8'hFF (DWIDTH bits), word shifted out when the TX holding register is empty at word start.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- ss_n  input  1  SPI select, active low, asynchronous to clk.
- sclk  input  1  SPI clock from master, asynchronous to clk.
- mosi  input  1  serial data from master.
- miso  output  1  serial data to master; 0 when not selected.
- tx_data  input  DWIDTH  word to transmit.
- tx_load  input  1  write tx_data into TX holding register.
- tx_ready  output  1  TX holding register empty.
- rx_data  output  DWIDTH  last complete received word.
- rx_valid  output  1  rx_data holds an unacknowledged word.
- rx_ack  input  1  consumer has taken rx_data.
- active  output  1  frame in progress (synchronised ss_n low).

Behaviour:
- Reset values, applied on the clk edge with rst=1:
  - miso=0, tx_ready=1, rx_data=0, rx_valid=0, active=0.
  - Bit counter 0, shift registers 0.
  - Synchronisers set to ss_n=1, sclk=0.
- Synchronisers:
  - Each of ss_n, sclk and mosi passes through 2 flops (s1, s2), plus a third flop (s3) for edge history.
  - Rise = s2 & ~s3; fall = ~s2 & s3.
  - mosi is sampled from its s2 stage.
- FSM states:
  - IDLE: ss_n_s2=1.
    - active=0, miso=0, bit_cnt=0.
    - On ss_n_s2=0, go to LOAD.
  - LOAD, 1 cycle:
    - tx_shift <= TX holding register if tx_ready=0, else TX_IDLE.
    - If the holding register was used, tx_ready <= 1.
    - active=1; go to SHIFT.
  - SHIFT:
    - On rise: miso <= tx_shift[MSB]; tx_shift <= tx_shift<<1.
    - On fall: rx_shift <= {rx_shift[DWIDTH-2:0], mosi_s2}; bit_cnt++.
    - When a fall makes bit_cnt reach DWIDTH:
      - Same edge: rx_data <= {rx_shift[DWIDTH-2:0], mosi_s2}; rx_valid <= 1; bit_cnt <= 0.
      - Next state is LOAD, which reloads for back-to-back words inside one frame.
- ss_n deasserted mid-word:
  - Go to IDLE, discard the partial word, no rx_valid, miso <= 0.
  - A TX word already moved into tx_shift is lost and is not restored.
- Latency: rx_valid rises 3 clk edges after the final sclk fall is first captured by s1.
- TX handshake:
  - tx_load with tx_ready=1: holding <= tx_data; tx_ready <= 0.
  - tx_load with tx_ready=0: overwrites holding; tx_ready stays 0.
  - tx_load in the same cycle as LOAD consumes the holding register: LOAD uses the old contents and the new word lands in holding (tx_ready=0).
- RX handshake:
  - rx_ack clears rx_valid.
  - If a new word completes in the same cycle as rx_ack, the new word wins and rx_valid stays 1.
  - A new word with rx_valid=1 and no ack overwrites rx_data.
- Simultaneous rise and fall cannot occur. rst mid-frame returns to IDLE regardless of ss_n; if ss_n is still low, the block re-enters LOAD.

Optional Feature:
- Macro: SPI_SLAVE_OVERRUN_EN.
- With the macro defined:
  - Adds output rx_overrun (1 bit), reset 0.
  - Set when a word completes while rx_valid=1 and rx_ack=0 in that cycle.
  - Cleared by rx_ack; set has priority over clear.
  - Adds output tx_underrun (1 bit), set when LOAD substitutes TX_IDLE and cleared by tx_load.
- Without the macro: ports absent, overwrite behaviour unchanged.

Decomposition:
- Shared package spi_pkg holds:
  - Mode constants CPOL=0, CPHA=1 (common with the master).
  - FSM state encoding IDLE/LOAD/SHIFT.
  - Default TX_IDLE.
- One natural sub-module: spi_sync_edge, a 3-flop synchroniser with rise/fall outputs, instantiated for sclk and ss_n. mosi uses its 2-flop path only.

Test Plan:
- After reset, holding ss_n=1 and toggling sclk: miso=0, active=0, rx_valid=0, tx_ready=1.
- tx_load 0xA5, then master sends 0x3C at clk/8: miso bit stream is 1,0,1,0,0,1,0,1 on rises; rx_data=0x3C; rx_valid rises 3 clk after the last fall; tx_ready=1.
- No tx_load, frame of 0x81: miso shifts 0xFF (TX_IDLE); rx_data=0x81.
- Two back-to-back words 0x12, 0x34 in one frame without rx_ack: rx_data ends at 0x34, rx_valid=1; with SPI_SLAVE_OVERRUN_EN, rx_overrun=1 until rx_ack.
- ss_n raised after 5 bits of 0xF0: no rx_valid; the next full frame 0x55 receives 0x55 correctly.
- rst pulsed after bit 3 with ss_n held low: all outputs at reset values, then the full next word 0x99 is received correctly.
